stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Control FSM for the StopWatch counter datapath (minutes/seconds/m_seconds).
//  - Turns raw set (start/stop) and clear (lap/reset) buttons into clean single-cycle events.
//  - Generates the centisecond count tick and the datapath clear.
//  - Captures a lap time and muxes live or lap time onto the display outputs.
// PARAMETERS
//  DIV      1_000_000  m_clk cycles per centisecond tick (100 MHz -> 10 ms); legal range >= 2
//  CNT_W    20         prescaler width; must satisfy 2**CNT_W >= DIV
// PORTS
//  m_clk           in   1  system clock; all logic on the rising edge
//  reset           in   1  synchronous, active-high reset
//  set             in   1  start/stop button, asynchronous level
//  clear           in   1  lap/reset button, asynchronous level
//  minutes         in   6  live datapath minutes (0-59)
//  seconds         in   6  live datapath seconds (0-59)
//  m_seconds       in   7  live datapath centiseconds (0-99)
//  tick            out  1  one-cycle count enable to the datapath
//  clr_cnt         out  1  one-cycle synchronous clear to the datapath
//  run_en          out  1  high in RUN or LAP
//  lap_active      out  1  high in LAP; display frozen
//  state           out  2  IDLE=0, RUN=1, STOP=2, LAP=3
//  disp_minutes    out  6  display minutes
//  disp_seconds    out  6  display seconds
//  disp_m_seconds  out  7  display centiseconds
// BEHAVIOUR
//  Reset values
//  - state=IDLE; tick=0; clr_cnt=0; run_en=0; lap_active=0.
//  - Prescaler=0; lap registers=0; synchroniser flops=0.
//  Input events
//  - Each button passes a 2-flop synchroniser plus a rising-edge detector.
//  - An input that rises before edge k yields a one-cycle event; state updates at edge k+2.
//  - A level held high produces exactly one event. There is no debounce.
//  FSM transitions (sE = set event, cE = clear event)
//  - IDLE: sE -> RUN; prescaler := 0.
//  - RUN:  sE -> STOP; cE -> LAP; lap regs := {minutes, seconds, m_seconds} sampled that edge.
//  - LAP:  sE -> STOP; display returns live. cE -> RUN; display returns live.
//  - STOP: sE -> RUN; prescaler resumes from its held value. cE -> IDLE; clr_cnt=1 for 1 cycle.
//  - IDLE + cE: stay in IDLE; clr_cnt pulses anyway.
//  - Simultaneous sE and cE: sE wins and cE is dropped.
//  Prescaler
//  - Counts only in RUN/LAP and holds in STOP/IDLE.
//  - At DIV-1 it wraps to 0 and tick=1 for that cycle.
//  - First tick comes DIV cycles after entering RUN from IDLE.
//  - tick is registered and never asserted outside RUN/LAP.
//  Lap capture
//  - A tick on the capture edge does not affect the captured value; the pre-increment value is stored.
//  Display
//  - Combinational mux: lap regs when lap_active, otherwise the live inputs. Zero latency.
//  - Live inputs are passed through unmodified; the datapath owns 59/99 wrap.
//  Reset mid-operation
//  - Any state returns to IDLE and the lap is lost.
//  - Pending synchroniser edges are discarded.
//  - The datapath is reset by the same reset, so no clr_cnt pulse is issued.
// STRUCTURE
//  - stopwatch_pkg: state encoding localparams and time-field widths (6/6/7).
//  - Sub-module btn_sync_edge: 2FF sync + edge detect; instantiated for set and clear.
//  - Top level holds the FSM, prescaler, lap registers and display mux.
// TESTING  (DIV=4 in simulation)
//  1. reset high 3 cycles -> all outputs 0, state=0; tick stays 0 with no buttons pressed.
//  2. set pulse -> state=1 two edges later; tick every 4th cycle; hold set 20 cycles -> single event only.
//  3. RUN, minutes=1 seconds=2 m_seconds=3, clear pulse -> state=3; disp shows 1/2/3 while inputs change;
//     second clear pulse -> state=1 and disp follows live.
//  4. RUN, 2 cycles into prescaler, set -> STOP, no ticks; set again -> next tick after 2 more cycles.
//  5. STOP, clear pulse -> state=0, clr_cnt high exactly 1 cycle; set and clear same cycle in RUN -> STOP, no lap.
//  6. reset asserted in LAP -> next edge: state=0, lap regs 0, disp shows live, tick=0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Stopwatch control package.
// Holds the FSM state encoding, the time-field widths shared by the
// controller and the datapath, and the packed time-stamp type used for
// lap capture.
package stopwatch_pkg;

  localparam int MIN_W = 6;
  localparam int SEC_W = 6;
  localparam int MS_W  = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2,
    ST_LAP  = 2'd3
  } sw_state_t;

  typedef struct packed {
    logic [MIN_W-1:0] minutes;
    logic [SEC_W-1:0] seconds;
    logic [MS_W-1:0]  m_seconds;
  } sw_time_t;

  function automatic logic is_counting(input sw_state_t s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_sync_edge.sv
// Button conditioning for the stopwatch controller.
// Two-flop synchroniser followed by a rising-edge detector. A level held
// high yields exactly one single-cycle event; there is no debounce.
// Ports:
//   m_clk  in  system clock, rising edge
//   reset  in  synchronous active-high reset; clears all flops so any
//              edge still in flight is discarded
//   btn    in  raw asynchronous button level
//   evt    out one-cycle event, valid the cycle after the level reaches
//              the second synchroniser stage
module btn_sync_edge (
  input  logic m_clk,
  input  logic reset,
  input  logic btn,
  output logic evt
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge m_clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign evt = sync2_q & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM.
// Conditions the set (start/stop) and clear (lap/reset) buttons, runs the
// centisecond prescaler, issues the datapath tick and clear, captures lap
// times and muxes live or lap time onto the display.
// Ports:
//   m_clk, reset                   clock and synchronous active-high reset
//   set, clear                     raw asynchronous buttons
//   minutes, seconds, m_seconds    live datapath time
//   tick                           one-cycle datapath count enable
//   clr_cnt                        one-cycle datapath clear
//   run_en                         high in RUN or LAP
//   lap_active                     high in LAP (display frozen)
//   state                          IDLE=0 RUN=1 STOP=2 LAP=3
//   disp_*                         display time (lap or live)
//
// state | meaning
// IDLE  | cleared, prescaler held, waiting for start
// RUN   | counting, display live
// STOP  | paused, prescaler holds its value for resume
// LAP   | counting, display frozen on captured lap time
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIV   = 1_000_000,
  parameter int CNT_W = 20
) (
  input  logic             m_clk,
  input  logic             reset,
  input  logic             set,
  input  logic             clear,
  input  logic [MIN_W-1:0] minutes,
  input  logic [SEC_W-1:0] seconds,
  input  logic [MS_W-1:0]  m_seconds,
  output logic             tick,
  output logic             clr_cnt,
  output logic             run_en,
  output logic             lap_active,
  output logic [1:0]       state,
  output logic [MIN_W-1:0] disp_minutes,
  output logic [SEC_W-1:0] disp_seconds,
  output logic [MS_W-1:0]  disp_m_seconds
);

  localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(DIV - 1);

  logic set_evt, clr_evt;

  sw_state_t        state_q, state_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic             tick_q,  tick_d;
  logic             clr_q,   clr_d;
  sw_time_t         lap_q,   lap_d;
  sw_time_t         live;

  btn_sync_edge u_set_sync (
    .m_clk (m_clk),
    .reset (reset),
    .btn   (set),
    .evt   (set_evt)
  );

  btn_sync_edge u_clr_sync (
    .m_clk (m_clk),
    .reset (reset),
    .btn   (clear),
    .evt   (clr_evt)
  );

  assign live = '{minutes: minutes, seconds: seconds, m_seconds: m_seconds};

  // set has priority everywhere: a simultaneous clear event is dropped.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    clr_d   = 1'b0;
    lap_d   = lap_q;

    case (state_q)
      ST_IDLE: begin
        if (set_evt) begin
          state_d = ST_RUN;
          presc_d = '0;
        end else if (clr_evt) begin
          clr_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (set_evt) begin
          state_d = ST_STOP;
        end else if (clr_evt) begin
          state_d = ST_LAP;
          lap_d   = live;
        end
      end
      ST_LAP: begin
        if (set_evt) begin
          state_d = ST_STOP;
        end else if (clr_evt) begin
          state_d = ST_RUN;
        end
      end
      ST_STOP: begin
        if (set_evt) begin
          state_d = ST_RUN;
        end else if (clr_evt) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Prescaler advances on every edge spent in RUN/LAP, including the edge
    // that leaves them; the tick is suppressed if that edge leaves counting
    // so the registered tick never shows up in STOP/IDLE.
    if (is_counting(state_q)) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        tick_d  = is_counting(state_d);
      end else begin
        presc_d = presc_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge m_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
      lap_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      clr_q   <= clr_d;
      lap_q   <= lap_d;
    end
  end

  assign tick       = tick_q;
  assign clr_cnt    = clr_q;
  assign state      = state_q;
  assign run_en     = is_counting(state_q);
  assign lap_active = (state_q == ST_LAP);

  always_comb begin
    if (lap_active) begin
      disp_minutes   = lap_q.minutes;
      disp_seconds   = lap_q.seconds;
      disp_m_seconds = lap_q.m_seconds;
    end else begin
      disp_minutes   = minutes;
      disp_seconds   = seconds;
      disp_m_seconds = m_seconds;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

  logic       m_clk = 1'b0;
  logic       reset = 1'b1;
  logic       set   = 1'b0;
  logic       clear = 1'b0;
  logic [5:0] minutes   = '0;
  logic [5:0] seconds   = '0;
  logic [6:0] m_seconds = '0;
  logic       tick, clr_cnt, run_en, lap_active;
  logic [1:0] state;
  logic [5:0] disp_minutes, disp_seconds;
  logic [6:0] disp_m_seconds;

  int errors = 0;
  int checks = 0;

  stopwatch_ctrl #(.DIV(4), .CNT_W(3)) dut (
    .m_clk          (m_clk),
    .reset          (reset),
    .set            (set),
    .clear          (clear),
    .minutes        (minutes),
    .seconds        (seconds),
    .m_seconds      (m_seconds),
    .tick           (tick),
    .clr_cnt        (clr_cnt),
    .run_en         (run_en),
    .lap_active     (lap_active),
    .state          (state),
    .disp_minutes   (disp_minutes),
    .disp_seconds   (disp_seconds),
    .disp_m_seconds (disp_m_seconds)
  );

  always #5 m_clk = ~m_clk;

  task automatic step();
    @(posedge m_clk);
    #1;
  endtask

  // One-cycle button pulse; returns just after the edge where the FSM updates.
  task automatic press_set();
    set = 1'b1; step(); set = 1'b0; step(); step();
  endtask

  task automatic press_clear();
    clear = 1'b1; step(); clear = 1'b0; step(); step();
  endtask

  task automatic set_live(input logic [5:0] mi, input logic [5:0] se, input logic [6:0] ms);
    minutes = mi; seconds = se; m_seconds = ms; #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_live(6'd12, 6'd34, 7'd56);
    step(); step(); step();
    checks++;
    if ({state, tick, clr_cnt, run_en, lap_active} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got state=%0d tick=%b clr=%b run=%b lap=%b, want all 0",
               state, tick, clr_cnt, run_en, lap_active);
    end
    checks++;
    if ({disp_minutes, disp_seconds, disp_m_seconds} !== {6'd12, 6'd34, 7'd56}) begin
      errors++;
      $display("FAIL reset_disp_live: got %0d/%0d/%0d want 12/34/56",
               disp_minutes, disp_seconds, disp_m_seconds);
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (tick !== 1'b0 || state !== 2'd0) begin
        errors++;
        $display("FAIL idle_quiet[%0d]: got tick=%b state=%0d want 0/0", i, tick, state);
      end
    end
  endtask

  task automatic test_start_tick();
    press_set();
    checks++;
    if (state !== 2'd1 || run_en !== 1'b1) begin
      errors++;
      $display("FAIL start_run: got state=%0d run_en=%b want 1/1", state, run_en);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (tick !== ((i % 4) == 3)) begin
        errors++;
        $display("FAIL tick_period[%0d]: got %b want %b", i, tick, (i % 4) == 3);
      end
    end
    // Hold set for 20 cycles: exactly one event -> STOP, never back to RUN.
    set = 1'b1;
    step(); step(); step();
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL hold_first_event: got state=%0d want 2", state);
    end
    for (int i = 0; i < 17; i++) step();
    checks++;
    if (state !== 2'd2 || tick !== 1'b0) begin
      errors++;
      $display("FAIL hold_single_event: got state=%0d tick=%b want 2/0", state, tick);
    end
    set = 1'b0;
    step(); step(); step();
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL release_no_event: got state=%0d want 2", state);
    end
  endtask

  task automatic test_lap();
    press_set();
    set_live(6'd1, 6'd2, 7'd3);
    press_clear();
    checks++;
    if (state !== 2'd3 || lap_active !== 1'b1 || run_en !== 1'b1) begin
      errors++;
      $display("FAIL lap_enter: got state=%0d lap=%b run=%b want 3/1/1", state, lap_active, run_en);
    end
    set_live(6'd5, 6'd6, 7'd7);
    checks++;
    if ({disp_minutes, disp_seconds, disp_m_seconds} !== {6'd1, 6'd2, 7'd3}) begin
      errors++;
      $display("FAIL lap_frozen: got %0d/%0d/%0d want 1/2/3",
               disp_minutes, disp_seconds, disp_m_seconds);
    end
    step(); step();
    checks++;
    if ({disp_minutes, disp_seconds, disp_m_seconds} !== {6'd1, 6'd2, 7'd3}) begin
      errors++;
      $display("FAIL lap_held: got %0d/%0d/%0d want 1/2/3",
               disp_minutes, disp_seconds, disp_m_seconds);
    end
    press_clear();
    checks++;
    if (state !== 2'd1 || lap_active !== 1'b0) begin
      errors++;
      $display("FAIL lap_exit: got state=%0d lap=%b want 1/0", state, lap_active);
    end
    checks++;
    if ({disp_minutes, disp_seconds, disp_m_seconds} !== {6'd5, 6'd6, 7'd7}) begin
      errors++;
      $display("FAIL lap_exit_live: got %0d/%0d/%0d want 5/6/7",
               disp_minutes, disp_seconds, disp_m_seconds);
    end
    set_live(6'd9, 6'd10, 7'd11);
    checks++;
    if ({disp_minutes, disp_seconds, disp_m_seconds} !== {6'd9, 6'd10, 7'd11}) begin
      errors++;
      $display("FAIL live_follow: got %0d/%0d/%0d want 9/10/11",
               disp_minutes, disp_seconds, disp_m_seconds);
    end
  endtask

  task automatic test_stop_resume();
    reset = 1'b1; step(); reset = 1'b0;
    // Two set pulses one cycle apart: RUN at edge E, STOP at edge E+2.
    set = 1'b1; step(); set = 1'b0; step(); set = 1'b1; step();
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL resume_enter_run: got state=%0d want 1", state);
    end
    set = 1'b0; step(); step();
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL resume_enter_stop: got state=%0d want 2", state);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (tick !== 1'b0) begin
        errors++;
        $display("FAIL stop_no_tick[%0d]: got %b want 0", i, tick);
      end
    end
    press_set();
    checks++;
    if (state !== 2'd1 || tick !== 1'b0) begin
      errors++;
      $display("FAIL resume_run: got state=%0d tick=%b want 1/0", state, tick);
    end
    step();
    checks++;
    if (tick !== 1'b0) begin
      errors++;
      $display("FAIL resume_tick_early: got %b want 0", tick);
    end
    step();
    checks++;
    if (tick !== 1'b1) begin
      errors++;
      $display("FAIL resume_tick_held_count: got %b want 1", tick);
    end
  endtask

  task automatic test_clear_and_priority();
    press_set();
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL pre_clear_stop: got state=%0d want 2", state);
    end
    clear = 1'b1; step(); clear = 1'b0; step();
    checks++;
    if (clr_cnt !== 1'b0) begin
      errors++;
      $display("FAIL clr_early: got %b want 0", clr_cnt);
    end
    step();
    checks++;
    if (state !== 2'd0 || clr_cnt !== 1'b1) begin
      errors++;
      $display("FAIL stop_clear: got state=%0d clr=%b want 0/1", state, clr_cnt);
    end
    step();
    checks++;
    if (clr_cnt !== 1'b0) begin
      errors++;
      $display("FAIL clr_one_cycle: got %b want 0", clr_cnt);
    end
    press_clear();
    checks++;
    if (state !== 2'd0 || clr_cnt !== 1'b1) begin
      errors++;
      $display("FAIL idle_clear: got state=%0d clr=%b want 0/1", state, clr_cnt);
    end
    press_set();
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL prio_run: got state=%0d want 1", state);
    end
    set = 1'b1; clear = 1'b1; step(); set = 1'b0; clear = 1'b0; step(); step();
    checks++;
    if (state !== 2'd2 || lap_active !== 1'b0 || clr_cnt !== 1'b0) begin
      errors++;
      $display("FAIL set_wins: got state=%0d lap=%b clr=%b want 2/0/0", state, lap_active, clr_cnt);
    end
  endtask

  task automatic test_reset_mid_op();
    press_set();
    set_live(6'd7, 6'd8, 7'd9);
    press_clear();
    set_live(6'd40, 6'd41, 7'd42);
    checks++;
    if (state !== 2'd3 || {disp_minutes, disp_seconds, disp_m_seconds} !== {6'd7, 6'd8, 7'd9}) begin
      errors++;
      $display("FAIL lap_before_reset: got state=%0d disp=%0d/%0d/%0d want 3 7/8/9",
               state, disp_minutes, disp_seconds, disp_m_seconds);
    end
    reset = 1'b1;
    set_live(6'd20, 6'd30, 7'd40);
    step();
    checks++;
    if ({state, tick, clr_cnt, run_en, lap_active} !== 6'b0) begin
      errors++;
      $display("FAIL reset_in_lap: got state=%0d tick=%b clr=%b run=%b lap=%b want all 0",
               state, tick, clr_cnt, run_en, lap_active);
    end
    checks++;
    if ({disp_minutes, disp_seconds, disp_m_seconds} !== {6'd20, 6'd30, 7'd40}) begin
      errors++;
      $display("FAIL reset_disp_live: got %0d/%0d/%0d want 20/30/40",
               disp_minutes, disp_seconds, disp_m_seconds);
    end
    reset = 1'b0;
    // A set edge in flight when reset hits must be discarded.
    set = 1'b1; step(); set = 1'b0; reset = 1'b1; step(); reset = 1'b0;
    step(); step(); step();
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL pending_edge_dropped: got state=%0d want 0", state);
    end
  endtask

  initial begin
    test_reset();
    test_start_tick();
    test_lap();
    test_stop_resume();
    test_clear_and_priority();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
